fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the PC adder.
- Owns the PC register and drives `pc` to the adder.
- Selects the next PC from the adder's `pc_4` or a jump target.
- Runs a ready-based handshake to instruction memory.
- Loads the IF/ID pipeline register, honouring stall and flush from the hazard unit.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 34 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM states, jump select codes and helpers for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HELD  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_ABS = 2'b01;
    localparam logic [1:0] JMP_FWD = 2'b10;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register; squash wins over load, no load means hold.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (squash) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= next_instr;
            pc4   <= next_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select, ready-based imem handshake and IF/ID loading.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_4,
    input  logic [1:0]  jump,
    input  logic [31:0] jump_add,
    input  logic [31:0] jump_forward_add,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    state_t      state, next_state;
    logic [31:0] next_pc, target, redirect_pending, hold_instr, hold_pc4;
    logic [31:0] load_instr, load_pc4;
    logic        redirect, load, bubble, capture, pend_set;

    assign redirect  = (jump != JMP_SEQ) && !stall;
    assign target    = align4((jump == JMP_FWD) ? jump_forward_add : jump_add);
    assign imem_req  = !reset && (state != S_HELD);
    assign imem_addr = pc;

    always_comb begin
        next_state = state;
        next_pc    = pc;
        load       = 1'b0;
        bubble     = 1'b0;
        capture    = 1'b0;
        pend_set   = 1'b0;
        load_instr = imem_rdata;
        load_pc4   = pc_4;
        case (state)
            S_REQ: begin
                if (imem_ready) begin
                    if (redirect) begin
                        bubble  = 1'b1;
                        next_pc = target;
                    end else if (stall) begin
                        capture    = 1'b1;
                        next_state = S_HELD;
                    end else begin
                        load    = 1'b1;
                        next_pc = pc_4;
                    end
                end else if (redirect) begin
                    pend_set   = 1'b1;
                    next_state = S_REDIR;
                end
            end
            S_HELD: begin
                if (!stall) begin
                    next_state = S_REQ;
                    if (redirect) begin
                        bubble  = 1'b1;
                        next_pc = target;
                    end else begin
                        load       = 1'b1;
                        load_instr = hold_instr;
                        load_pc4   = hold_pc4;
                        next_pc    = pc_4;
                    end
                end
            end
            S_REDIR: begin
                // the in-flight word is wrong-path; drop it and take the latched target
                if (imem_ready) begin
                    bubble     = 1'b1;
                    next_pc    = redirect_pending;
                    next_state = S_REQ;
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_REQ;
            pc               <= RESET_PC;
            redirect_pending <= '0;
            hold_instr       <= '0;
            hold_pc4         <= '0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (pend_set)
                redirect_pending <= target;
            if (capture) begin
                hold_instr <= imem_rdata;
                hold_pc4   <= pc_4;
            end
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .squash     (flush || bubble),
        .next_instr (load_instr),
        .next_pc4   (load_pc4),
        .instr      (ifid_instr),
        .pc4        (ifid_pc4),
        .valid      (ifid_valid)
    );

endmodule
